// File: rtl/pipeline.sv
// Three-stage two-term dot product: C = A1*B1 + A2*B2 mod 2^WIDTH.
// Stage 1 registers operands, stage 2 registers truncated products, stage 3 registers the sum.

module pipeline_term #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p_r
);
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] prod;

    // Only the low WIDTH bits of the product can influence the wrapped result.
    assign prod = a_r * b_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            p_r <= '0;
        end else begin
            a_r <= a;
            b_r <= b;
            p_r <= prod;
        end
    end
endmodule

module pipeline #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B2,
    output logic [WIDTH-1:0] C
);
    localparam int NUM_TERMS = 2;

    logic [NUM_TERMS-1:0][WIDTH-1:0] a_in;
    logic [NUM_TERMS-1:0][WIDTH-1:0] b_in;
    logic [NUM_TERMS-1:0][WIDTH-1:0] p_r;

    assign a_in = {A2, A1};
    assign b_in = {B2, B1};

    for (genvar g = 0; g < NUM_TERMS; g++) begin : g_term
        pipeline_term #(.WIDTH(WIDTH)) u_term (
            .clk (clk),
            .rst (rst),
            .a   (a_in[g]),
            .b   (b_in[g]),
            .p_r (p_r[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) C <= '0;
        else     C <= p_r[0] + p_r[1];
    end
endmodule

// File: tb/tb_pipeline.sv
// Scoreboard bench for the dot-product pipeline: the driver queues the hand-computed
// result with its due cycle, the monitor pops and compares on every falling edge.

module tb_pipeline;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] A1, B1, A2, B2;
    logic [WIDTH-1:0] C;

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               due;
        string            tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    pipeline #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .A1  (A1),
        .B1  (B1),
        .A2  (A2),
        .B2  (B2),
        .C   (C)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: results are due a fixed number of edges after issue.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            n_checks++;
            if (e.due < cyc) begin
                n_fail++;
                $display("FAIL %s missed slot: due cycle %0d, now %0d", e.tag, e.due, cyc);
            end else if (C !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d C=%h expected=%h", e.tag, cyc, C, e.exp);
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] exp, input int due, input string tag);
        exp_t e;
        e.exp = exp;
        e.due = due;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                         input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2,
                         input logic [WIDTH-1:0] exp, input string tag);
        rst = r;
        A1  = a1;
        B1  = b1;
        A2  = a2;
        B2  = b2;
        push_exp(exp, cyc + 3, tag);
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] ra1, rb1, ra2, rb2;
        logic [2*WIDTH+1:0] full;

        // Reset edges 1 and 2 force C to 0 regardless of earlier content.
        push_exp('0, 1, "reset_edge1");
        push_exp('0, 2, "reset_edge2");
        drive(1'b1, $urandom, $urandom, $urandom, $urandom, 32'd0, "reset_rand0");
        drive(1'b1, $urandom, $urandom, $urandom, $urandom, 32'd0, "reset_rand1");
        drive(1'b0, 0, 0, 0, 0, 32'd0, "post_reset0");
        drive(1'b0, 0, 0, 0, 0, 32'd0, "post_reset1");
        drive(1'b0, 0, 0, 0, 0, 32'd0, "post_reset2");

        drive(1'b0, 1, 2, 3, 4, 32'd14, "basic");
        drive(1'b0, 0, 1, 0, 1, 32'd0,  "basic_zero");

        drive(1'b0, 1, 1, 1, 1,     32'd2,   "stream0");
        drive(1'b0, 2, 3, 4, 5,     32'd26,  "stream1");
        drive(1'b0, 10, 10, 10, 10, 32'd200, "stream2");

        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'h0000_0001, "wrap_sq");
        drive(1'b0, 32'h8000_0000, 2, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, "wrap_prod");
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, "wrap_both");
        drive(1'b0, 32'h0000_FFFF, 32'h0001_0001, 1, 1, 32'd0, "carry_drop");

        // Reset mid-stream: the two sets in flight at the reset edge are lost.
        drive(1'b0, 3, 3, 3, 3,     32'd18, "pre_reset");
        drive(1'b0, 5, 6, 7, 8,     32'd0,  "lost0");
        drive(1'b0, 9, 9, 9, 9,     32'd0,  "lost1");
        drive(1'b1, 11, 12, 13, 14, 32'd0,  "mid_reset");
        drive(1'b0, 2, 2, 3, 3,     32'd13, "after_reset0");
        drive(1'b0, 4, 4, 1, 1,     32'd17, "after_reset1");

        for (int i = 0; i < 1000; i++) begin
            ra1 = $urandom; rb1 = $urandom; ra2 = $urandom; rb2 = $urandom;
            full = ({34'd0, ra1} * {34'd0, rb1}) + ({34'd0, ra2} * {34'd0, rb2});
            drive(1'b0, ra1, rb1, ra2, rb2, full[WIDTH-1:0], "random");
        end

        for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 0, 0, 32'd0, "drain");

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline.md
# pipeline

Three-stage pipelined two-term dot-product unit. On every clock it accepts two operand pairs, (A1, B1) and (A2, B2), and produces C = A1·B1 + A2·B2, modulo 2^WIDTH. It is a free-running datapath with no handshake: one new operand set enters per cycle, and one result leaves per cycle after a fixed latency. It sits in the arithmetic datapath as a building block for multiply-accumulate chains.

## Interface
Parameters:
- WIDTH, default 32: width of every operand, intermediate value and result.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high; clears all pipeline registers.
- A1  input  WIDTH  first operand of product 1, unsigned.
- B1  input  WIDTH  second operand of product 1, unsigned.
- A2  input  WIDTH  first operand of product 2, unsigned.
- B2  input  WIDTH  second operand of product 2, unsigned.
- C  output  WIDTH  registered result, A1·B1 + A2·B2 mod 2^WIDTH.

## Operation
- Stage 1 (input register): on each rising edge, capture A1, B1, A2 and B2 into the stage-1 registers a1_r, b1_r, a2_r and b2_r.
- Stage 2 (multiply):
  - Compute p1 = a1_r·b1_r and p2 = a2_r·b2_r.
  - Truncate each product to its low WIDTH bits.
  - Register both truncated products.
- Stage 3 (add):
  - Compute C = p1_r + p2_r.
  - Truncate the sum to WIDTH bits; the carry-out is discarded.
  - Register the sum directly onto C. C is driven only by this register and has no combinational path from the inputs.
- Arithmetic rules:
  - All arithmetic is unsigned.
  - Overflow wraps silently; there is no saturation and no flag.
  - The result must equal the full-precision A1·B1 + A2·B2 reduced mod 2^WIDTH.
- There is no valid or enable signal. Every stage advances on every clock edge, and the pipeline cannot be stalled.
- Reset:
  - When rst = 1 at a rising edge, all stage-1, stage-2 and stage-3 registers load 0.
  - C is therefore 0 from that edge onward while rst is held.
  - rst has priority over data capture.
- Reset released mid-operation: operand sets that were in flight are lost. Zeros drain out of the pipeline, so C stays 0 until the first operand set sampled after reset release emerges.

## Timing
- Latency: 3 rising edges. Operands sampled at edge n appear on C immediately after edge n+2, counting the sampling edge as the first.
- Throughput: one result per cycle. Consecutive operand sets produce consecutive results in order, with no bubbles.
- Reset value of C: 0. C reads 0 for the first 3 edges after reset release when the inputs are held at 0.
- Inputs must be stable around the rising edge. They may change at any point between edges.
- Behaviour before the first reset is undefined. In simulation, C may be X until 3 edges of defined input have passed or until a reset has been applied.
- Critical path: one WIDTH×WIDTH multiplier, from a register to a register. A synthesized `*` operator is acceptable. An explicit partial-product implementation must keep the same 3-cycle latency.

## Test plan
- Reset: hold rst = 1 for 2 edges with random inputs -> C = 0 on every cycle; after release with inputs at 0 -> C stays 0.
- Basic: A1=1, B1=2, A2=3, B2=4 for one cycle, then A1=0, B1=1, A2=0, B2=1 -> C = 14 (0x0000000E) 3 edges after the first set is sampled, then C = 0 on the next cycle.
- Back-to-back stream: apply (1,1,1,1), (2,3,4,5), (10,10,10,10) on consecutive cycles, with arguments in the order A1,B1,A2,B2 -> C = 2, 26, 200 on three consecutive cycles.
- Wrap-around:
  - A1=B1=0xFFFFFFFF, A2=B2=0 -> C = 0x00000001.
  - A1=0x80000000, B1=2, A2=0xFFFFFFFF, B2=1 -> C = 0xFFFFFFFF.
- Reset mid-stream: stream nonzero operand sets and assert rst for one edge -> C = 0 for that cycle and the following 2 cycles, then results from operand sets sampled after release, with no stale data.
- Random: 1000 random operand sets compared against a reference model delayed by 3 cycles, (A1·B1 + A2·B2) mod 2^32 -> zero mismatches.
